// File: rtl/uart_rx.sv
// UART receiver: synchronises the async rx line, validates the start bit, deserialises
// 8N1 frames LSB first and hands each byte to the bus with a valid/ack handshake.
module uart_rx #(
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       os_tick_i,
    input  logic       rx_i,
    input  logic       rd_ack_i,
    output logic [7:0] rxdata_o,
    output logic       rx_valid_o,
    output logic       frame_err_o,
    output logic       overrun_o,
    output logic [1:0] rx_state_o
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        START = 2'b01,
        DATA  = 2'b11,
        STOP  = 2'b10
    } state_t;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rs;

    state_t          state_q;
    logic [TW-1:0]   tick_q;
    logic [TW-1:0]   tick_d;
    logic [2:0]      bit_q;
    logic [7:0]      sh_q;
    logic [7:0]      sh_d;
    logic            armed_q;
    logic [7:0]      rxdata_q;
    logic            valid_q;
    logic            ferr_q;
    logic            ovr_q;

    // Idle-high reset value keeps a fresh reset from looking like a start edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], rx_i};
        end
    end

    assign rs     = sync_q[SYNC_STAGES-1];
    assign tick_d = tick_q + TW'(1);
    assign sh_d   = {rs, sh_q[7:1]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            tick_q   <= '0;
            bit_q    <= '0;
            sh_q     <= '0;
            armed_q  <= 1'b0;
            rxdata_q <= '0;
            valid_q  <= 1'b0;
            ferr_q   <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            // Acknowledge clears first so a same-cycle frame event below overrides it.
            if (rd_ack_i) begin
                valid_q <= 1'b0;
                ferr_q  <= 1'b0;
                ovr_q   <= 1'b0;
            end

            if (os_tick_i) begin
                case (state_q)
                    IDLE: begin
                        if (rs) begin
                            armed_q <= 1'b1;
                        end else if (armed_q) begin
                            state_q <= START;
                            tick_q  <= '0;
                        end
                    end
                    START: begin
                        if (tick_q == MID_START) begin
                            tick_q <= '0;
                            if (!rs) begin
                                state_q <= DATA;
                                bit_q   <= '0;
                            end else begin
                                state_q <= IDLE;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                    DATA: begin
                        if (tick_q == LAST_TICK) begin
                            tick_q <= '0;
                            sh_q   <= sh_d;
                            bit_q  <= bit_q + 3'd1;
                            if (bit_q == 3'd7) begin
                                state_q <= STOP;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                    STOP: begin
                        if (tick_q == LAST_TICK) begin
                            tick_q  <= '0;
                            state_q <= IDLE;
                            armed_q <= 1'b0;
                            if (rs) begin
                                if (!valid_q || rd_ack_i) begin
                                    rxdata_q <= sh_q;
                                    valid_q  <= 1'b1;
                                end else begin
                                    ovr_q <= 1'b1;
                                end
                            end else begin
                                ferr_q <= 1'b1;
                            end
                        end else begin
                            tick_q <= tick_d;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        tick_q  <= '0;
                    end
                endcase
            end
        end
    end

    assign rxdata_o    = rxdata_q;
    assign rx_valid_o  = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;
    assign rx_state_o  = state_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: directed scenarios plus random frames, checked against a
// frame-level model of the received byte, valid handshake and sticky flags.
module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       os_tick;
    logic       rx;
    logic       rd_ack;
    logic [7:0] rxdata;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;
    logic [1:0] rx_state;

    int compareCount = 0;
    int failCount    = 0;
    int tickDiv      = 0;

    logic [7:0] expData;
    logic       expValid;
    logic       expFerr;
    logic       expOvr;

    uart_rx #(.OVERSAMPLE(16), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .os_tick_i  (os_tick),
        .rx_i       (rx),
        .rd_ack_i   (rd_ack),
        .rxdata_o   (rxdata),
        .rx_valid_o (rx_valid),
        .frame_err_o(frame_err),
        .overrun_o  (overrun),
        .rx_state_o (rx_state)
    );

    always #5 clk = ~clk;

    // Oversampling tick: one clock high out of every four.
    initial begin
        os_tick = 1'b0;
        forever begin
            @(negedge clk);
            os_tick = (tickDiv == 3);
            tickDiv = (tickDiv + 1) % 4;
        end
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compareCount++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputs(input string tag);
        check({tag, "/rxdata"},    32'(rxdata),    32'(expData));
        check({tag, "/rx_valid"},  32'(rx_valid),  32'(expValid));
        check({tag, "/frame_err"}, 32'(frame_err), 32'(expFerr));
        check({tag, "/overrun"},   32'(overrun),   32'(expOvr));
    endtask

    task automatic waitTicks(input int n);
        int k = 0;
        while (k < n) begin
            @(posedge clk);
            if (os_tick) k++;
        end
    endtask

    task automatic sendBit(input logic b);
        @(negedge clk);
        rx = b;
        waitTicks(16);
    endtask

    task automatic sendIdle(input int n);
        for (int i = 0; i < n; i++) sendBit(1'b1);
    endtask

    task automatic doAck();
        @(negedge clk);
        rd_ack = 1'b1;
        @(posedge clk);
        #1;
        expValid = 1'b0;
        expFerr  = 1'b0;
        expOvr   = 1'b0;
        checkOutputs("ack");
        @(negedge clk);
        rd_ack = 1'b0;
    endtask

    // The stop bit is sampled on its 9th tick; the result must appear right after that edge.
    task automatic sendFrame(input logic [7:0] d, input logic stopBit, input logic ackAtStop);
        logic prevValid;
        waitTicks(1);
        sendBit(1'b0);
        for (int i = 0; i < 8; i++) sendBit(d[i]);
        @(negedge clk);
        rx = stopBit;
        waitTicks(8);
        #1;
        check("pre_stop/rx_state", 32'(rx_state), 32'h2);
        check("pre_stop/rx_valid", 32'(rx_valid), 32'(expValid));
        if (ackAtStop) begin
            do begin
                @(negedge clk);
                #1;
            end while (!os_tick);
            rd_ack = 1'b1;
        end
        waitTicks(1);
        #1;
        prevValid = expValid;
        if (ackAtStop) begin
            expValid = 1'b0;
            expFerr  = 1'b0;
            expOvr   = 1'b0;
        end
        if (stopBit) begin
            if (!prevValid || ackAtStop) begin
                expData  = d;
                expValid = 1'b1;
            end else begin
                expOvr = 1'b1;
            end
        end else begin
            expFerr = 1'b1;
        end
        checkOutputs("frame");
        check("frame/rx_state", 32'(rx_state), 32'h0);
        if (ackAtStop) begin
            @(negedge clk);
            rd_ack = 1'b0;
        end
        waitTicks(7);
    endtask

    initial begin
        logic [7:0] rd;
        logic       good;
        int         mode;

        rst      = 1'b1;
        rx       = 1'b1;
        rd_ack   = 1'b0;
        expData  = 8'h00;
        expValid = 1'b0;
        expFerr  = 1'b0;
        expOvr   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checkOutputs("reset");
        check("reset/rx_state", 32'(rx_state), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] idle line for 100 bit times");
        for (int i = 0; i < 100; i++) begin
            sendBit(1'b1);
            #1;
            check("idle/status", {28'b0, rx_valid, frame_err, overrun, rx_state}, 32'h0);
        end

        $display("[TB] good frame 0xA5");
        sendFrame(8'hA5, 1'b1, 1'b0);
        doAck();

        $display("[TB] false start");
        sendIdle(1);
        waitTicks(1);
        @(negedge clk);
        rx = 1'b0;
        waitTicks(2);
        #1;
        check("glitch/rx_state_start", 32'(rx_state), 32'h1);
        waitTicks(2);
        @(negedge clk);
        rx = 1'b1;
        waitTicks(32);
        #1;
        checkOutputs("glitch");
        check("glitch/rx_state_idle", 32'(rx_state), 32'h0);

        $display("[TB] framing error then recovery");
        sendFrame(8'h3C, 1'b0, 1'b0);
        @(negedge clk);
        rx = 1'b0;
        waitTicks(48);
        #1;
        check("break/rx_state", 32'(rx_state), 32'h0);
        checkOutputs("break");
        sendIdle(2);
        sendFrame(8'h01, 1'b1, 1'b0);
        doAck();

        $display("[TB] overrun and same-cycle ack");
        sendIdle(1);
        sendFrame(8'h11, 1'b1, 1'b0);
        sendIdle(1);
        sendFrame(8'h22, 1'b1, 1'b0);
        doAck();
        sendIdle(1);
        sendFrame(8'h11, 1'b1, 1'b0);
        sendIdle(1);
        sendFrame(8'h22, 1'b1, 1'b1);

        $display("[TB] reset in the middle of a frame");
        sendIdle(1);
        waitTicks(1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        #1;
        check("midframe/rx_state", 32'(rx_state), 32'h3);
        #2;
        rst = 1'b1;
        #1;
        expData  = 8'h00;
        expValid = 1'b0;
        expFerr  = 1'b0;
        expOvr   = 1'b0;
        checkOutputs("async_reset");
        check("async_reset/rx_state", 32'(rx_state), 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sendIdle(2);
        sendFrame(8'h5A, 1'b1, 1'b0);

        $display("[TB] random frames");
        for (int n = 0; n < 12; n++) begin
            rd   = 8'($urandom);
            good = ($urandom_range(0, 4) != 0);
            mode = $urandom_range(0, 2);
            if (mode == 1) doAck();
            sendIdle($urandom_range(1, 2));
            sendFrame(rd, good, (mode == 2) && good);
        end
        doAck();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
        $finish;
    end

endmodule
